// File: rtl/fir_axis_out_buffer.sv
// Output stage of the FIR core: buffers the y[n] AXI-Stream in a small FIFO, re-issues it
// downstream, forces m_tlast on sample cfg_len and flags upstream tlast disagreement.
module fir_axis_out_buffer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 4,
  parameter int pCNT_WIDTH  = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [pCNT_WIDTH-1:0]  cfg_len,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   len_err,
  output logic [pCNT_WIDTH-1:0]  out_count
);

  localparam int AW = $clog2(pDEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [pCNT_WIDTH-1:0]  len_q;
  logic [pCNT_WIDTH-1:0]  out_count_q;
  logic                   len_err_q;
  logic [pDATA_WIDTH-1:0] data_mem [pDEPTH];
  logic [pDEPTH-1:0]      last_mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            occ;
  logic                   full, push, pop, tag_last, start_ok;

  // full comes straight from the occupancy register, so ready never depends on m_tready
  assign full     = (occ == (AW+1)'(pDEPTH));
  assign s_tready = (state == RUN) && !full;
  assign push     = s_tvalid && s_tready;
  assign m_tvalid = (occ != '0);
  assign pop      = m_tvalid && m_tready;
  assign m_tdata  = data_mem[rd_ptr];
  assign m_tlast  = m_tvalid && last_mem[rd_ptr];
  assign tag_last = ((out_count_q + pCNT_WIDTH'(1)) == len_q);
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign len_err   = len_err_q;
  assign out_count = out_count_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = (cfg_len == '0) ? DONE : RUN;
      RUN:        if (push && tag_last) state_nxt = DRAIN;
      DRAIN:      if (pop && m_tlast) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      out_count_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len_q       <= cfg_len;
        out_count_q <= '0;
        len_err_q   <= 1'b0;
      end else if (push) begin
        out_count_q <= out_count_q + pCNT_WIDTH'(1);
        if (s_tlast != tag_last) len_err_q <= 1'b1;
      end
    end
  end

  // FIFO storage is cleared on reset so m_tdata/m_tlast read back as zero
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < pDEPTH; i++) data_mem[i] <= '0;
      last_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= s_tdata;
        last_mem[wr_ptr] <= tag_last;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule
